// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Hazard and sequencing controller for a 5-stage pipeline.
//                Produces per-stage load enables and bubble flushes,
//                EX-operand forwarding selects, load-use stalls,
//                EX-resolved redirect flushes and a data-memory wait freeze
//                with a timeout that parks the pipeline in a sticky error
//                state.
//                Optional feature macro: PIPE_PERF_CNT_EN adds the
//                stall_cycles_o / flush_events_o performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,   // freeze cycles tolerated before ERR (>=2)
   parameter int CNT_W       = 8     // wait counter width, 2**CNT_W > MEM_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst_n,
   // ID stage sources
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic        id_rs1_used_i,
   input  logic        id_rs2_used_i,
   // EX stage
   input  logic [4:0]  ex_rs1_i,
   input  logic [4:0]  ex_rs2_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        ex_regwrite_i,
   input  logic        ex_memread_i,
   // MEM / WB destinations
   input  logic [4:0]  mem_rd_i,
   input  logic        mem_regwrite_i,
   input  logic [4:0]  wb_rd_i,
   input  logic        wb_regwrite_i,
   // Control-flow and data-memory handshake
   input  logic        ex_redirect_i,
   input  logic        dmem_req_i,
   input  logic        dmem_ready_i,
   // Stage load enables
   output logic        pc_en_o,
   output logic        if_id_en_o,
   output logic        id_ex_en_o,
   output logic        ex_mem_en_o,
   output logic        mem_wb_en_o,
   // Stage bubble inserts (a flush overrides the matching enable)
   output logic        if_id_flush_o,
   output logic        id_ex_flush_o,
   output logic        mem_wb_flush_o,
   // Forwarding selects: 00 RF, 01 EX/MEM result, 10 MEM/WB data
   output logic [1:0]  fwd_a_sel_o,
   output logic [1:0]  fwd_b_sel_o,
   // Status
   output logic        mem_err_o,
   output logic [1:0]  state_o
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles_o,
   output logic [31:0] flush_events_o
`endif
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'b00,
      ST_WAIT = 2'b01,
      ST_ERR  = 2'b10
   } state_e;

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

   state_e           state_q;
   logic [CNT_W-1:0] wait_cnt_q;
   logic             mem_err_q;

   logic             w_lduse;
   logic             w_mwait;
   logic             w_frozen;

   // Load in EX whose destination (never x0) is read by the instruction in ID.
   assign w_lduse = ex_memread_i & ex_regwrite_i & (ex_rd_i != 5'd0) &
                    ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                     (id_rs2_used_i & (id_rs2_i == ex_rd_i)));

   // Data memory has an access outstanding that does not complete this cycle.
   assign w_mwait  = dmem_req_i & ~dmem_ready_i;
   assign w_frozen = (state_q == ST_ERR);

   // Youngest producer wins: EX/MEM result ahead of MEM/WB data; x0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] m_rd,
                                          input logic       m_we,
                                          input logic [4:0] w_rd,
                                          input logic       w_we);
      logic [1:0] sel;
      sel = 2'b00;
      if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
         sel = 2'b01;
      end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   // Stage enable/flush priority: reset, error freeze, memory wait, redirect, load-use.
   always_comb begin
      pc_en_o        = 1'b1;
      if_id_en_o     = 1'b1;
      id_ex_en_o     = 1'b1;
      ex_mem_en_o    = 1'b1;
      mem_wb_en_o    = 1'b1;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      mem_wb_flush_o = 1'b0;
      if (!rst_n) begin
         pc_en_o        = 1'b0;
         if_id_en_o     = 1'b0;
         id_ex_en_o     = 1'b0;
         ex_mem_en_o    = 1'b0;
         mem_wb_en_o    = 1'b0;
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
         mem_wb_flush_o = 1'b1;
      end else if (w_frozen) begin
         pc_en_o        = 1'b0;
         if_id_en_o     = 1'b0;
         id_ex_en_o     = 1'b0;
         ex_mem_en_o    = 1'b0;
         mem_wb_en_o    = 1'b0;
      end else if (w_mwait) begin
         // Hold everything (a pending redirect in EX survives) and bubble WB.
         pc_en_o        = 1'b0;
         if_id_en_o     = 1'b0;
         id_ex_en_o     = 1'b0;
         ex_mem_en_o    = 1'b0;
         mem_wb_en_o    = 1'b0;
         mem_wb_flush_o = 1'b1;
      end else if (ex_redirect_i) begin
         // Wrong-path instructions in IF and ID are killed; a load-use there is moot.
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
      end else if (w_lduse) begin
         // Hold PC and IF/ID for one cycle and drop a bubble into EX.
         pc_en_o        = 1'b0;
         if_id_en_o     = 1'b0;
         id_ex_flush_o  = 1'b1;
      end
   end

   // Forwarding selects for both EX operands, neutral while in reset.
   always_comb begin
      fwd_a_sel_o = 2'b00;
      fwd_b_sel_o = 2'b00;
      if (rst_n) begin
         fwd_a_sel_o = fwd_sel(ex_rs1_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i);
         fwd_b_sel_o = fwd_sel(ex_rs2_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i);
      end
   end

   // Memory-wait FSM with saturating wait counter and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (w_mwait) begin
                  state_q    <= ST_WAIT;
                  wait_cnt_q <= CNT_ONE;
               end
            end
            ST_WAIT: begin
               if (dmem_ready_i) begin
                  state_q    <= ST_RUN;
                  wait_cnt_q <= '0;
               end else if (wait_cnt_q == TIMEOUT_CNT) begin
                  state_q    <= ST_ERR;
                  mem_err_q  <= 1'b1;
               end else if (wait_cnt_q != CNT_MAX) begin
                  wait_cnt_q <= wait_cnt_q + CNT_ONE;
               end
            end
            ST_ERR: begin
               mem_err_q <= 1'b1;
            end
            default: begin
               state_q    <= ST_RUN;
               wait_cnt_q <= '0;
            end
         endcase
      end
   end

   assign mem_err_o = mem_err_q;
   assign state_o   = state_q;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] stall_cycles_d;
   logic [31:0] flush_events_q;
   logic [31:0] flush_events_d;
   logic        w_stall_evt;
   logic        w_flush_evt;

   // A stall is charged to whichever of memory wait or load-use is the winning cause.
   assign w_stall_evt = ~w_frozen & (w_mwait | (w_lduse & ~ex_redirect_i));
   assign w_flush_evt = ~w_frozen & ~w_mwait & ex_redirect_i;

   assign stall_cycles_d = stall_cycles_q + {31'd0, w_stall_evt};
   assign flush_events_d = flush_events_q + {31'd0, w_flush_evt};

   // Free-running, wrapping event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_events_o = flush_events_q;
`else
`endif

endmodule
`default_nettype wire
